// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums NTERMS unsigned 8-bit products per result behind valid/ready ports
// Define PRODUCT_ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 on overflow instead of wrapping.
module product_accumulator #(
  parameter int NTERMS = 4,
  parameter int ACC_W  = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [7:0]       PRODUCT_IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [ACC_W-1:0] ACC_OUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OVF,
  output logic [7:0]       BEAT_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(NTERMS);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_acc_out;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_beat_cnt;

  logic             w_accept;
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;
  logic [7:0]       w_cnt_next;

  // One extra bit on the adder exposes the carry used for overflow detection.
  always_comb begin
    w_prod_ext      = '0;
    w_prod_ext[7:0] = PRODUCT_IN;
    w_sum           = {1'b0, r_acc} + w_prod_ext;
    w_carry         = w_sum[ACC_W];
`ifdef PRODUCT_ACC_SATURATE_EN
    w_acc_next      = w_carry ? '1 : w_sum[ACC_W-1:0];
`else
    w_acc_next      = w_sum[ACC_W-1:0];
`endif
  end

  assign w_accept   = IN_VALID & r_in_ready;
  assign w_cnt_next = r_beat_cnt + 8'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_acc_out   <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (START) begin
            // A beat arriving with the restart becomes beat 1 of the new sum.
            r_ovf <= 1'b0;
            if (w_accept) begin
              r_acc      <= w_prod_ext[ACC_W-1:0];
              r_beat_cnt <= 8'd1;
            end else begin
              r_acc      <= '0;
              r_beat_cnt <= '0;
            end
          end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_beat_cnt <= w_cnt_next;
            r_ovf      <= r_ovf | w_carry;
            if (w_cnt_next == LP_LAST) begin
              r_acc_out   <= w_acc_next;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end

        S_DONE: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_ovf       <= 1'b0;
            if (START) begin
              r_in_ready <= 1'b1;
              r_state    <= S_ACCUM;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign ACC_OUT   = r_acc_out;
  assign OVF       = r_ovf;
  assign BEAT_CNT  = r_beat_cnt;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - table-driven scoreboard bench for product_accumulator
// Unit 0 uses defaults (ACC_W=10); unit 1 uses ACC_W=9 for the overflow cases.
module tb_product_accumulator;

`ifdef PRODUCT_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] start     = '0;
  logic [1:0] in_valid  = '0;
  logic [1:0] out_ready = '0;
  logic [7:0] prod [2];

  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] ovf;
  logic [9:0] acc0;
  logic [8:0] acc1;
  logic [7:0] bc0;
  logic [7:0] bc1;

  product_accumulator #(.NTERMS(4), .ACC_W(10)) u_dut0 (
    .CLK(clk), .RST(rst), .START(start[0]), .PRODUCT_IN(prod[0]),
    .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .ACC_OUT(acc0),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .OVF(ovf[0]),
    .BEAT_CNT(bc0)
  );

  product_accumulator #(.NTERMS(4), .ACC_W(9)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start[1]), .PRODUCT_IN(prod[1]),
    .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .ACC_OUT(acc1),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .OVF(ovf[1]),
    .BEAT_CNT(bc1)
  );

  typedef struct packed {
    bit              u;
    logic [3:0][7:0] beats;
    logic [3:0][1:0] gaps;
    logic [3:0]      stall;
    logic [15:0]     exp_acc;
    bit              exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] acc;
    bit          ovf;
  } exp_t;

  vec_t vecs [7];
  exp_t sb_q [$];
  int   n_pass = 0;
  int   n_chk  = 0;

  function automatic int get_acc(input int u);
    return (u == 0) ? int'(acc0) : int'(acc1);
  endfunction

  function automatic int get_bc(input int u);
    return (u == 0) ? int'(bc0) : int'(bc1);
  endfunction

  function automatic vec_t mk(input int u, input int b0, input int b1, input int b2, input int b3,
                              input int g0, input int g1, input int g2, input int g3,
                              input int stall, input int ea, input int eo);
    vec_t v;
    v.u        = (u != 0);
    v.beats[0] = 8'(b0); v.beats[1] = 8'(b1); v.beats[2] = 8'(b2); v.beats[3] = 8'(b3);
    v.gaps[0]  = 2'(g0); v.gaps[1]  = 2'(g1); v.gaps[2]  = 2'(g2); v.gaps[3]  = 2'(g3);
    v.stall    = 4'(stall);
    v.exp_acc  = 16'(ea);
    v.exp_ovf  = (eo != 0);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    $display("FAIL %s: no response within 40 cycles", name);
  endtask

  task automatic pulse_start(input int u);
    start[u] = 1'b1;
    @(negedge clk);
    start[u] = 1'b0;
  endtask

  task automatic send(input int u, input int v, input int gap, input string name);
    int n = 0;
    in_valid[u] = 1'b0;
    repeat (gap) @(negedge clk);
    prod[u]     = 8'(v);
    in_valid[u] = 1'b1;
    while (!in_ready[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[u]) timeout_fail({name, " accept"});
    @(negedge clk);
    in_valid[u] = 1'b0;
  endtask

  task automatic wait_valid(input int u, input string name);
    int n = 0;
    while (!out_valid[u] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[u]) timeout_fail({name, " out_valid"});
  endtask

  task automatic compare_head(input int u, input int stall, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: result with no expected entry queued", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, " acc"}, get_acc(u), int'(e.acc));
    chk({name, " ovf"}, int'(ovf[u]), int'(e.ovf));
    chk({name, " beat_cnt"}, get_bc(u), 4);
    chk({name, " in_ready in done"}, int'(in_ready[u]), 0);
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({name, " valid held"}, int'(out_valid[u]), 1);
      chk({name, " acc stable"}, get_acc(u), int'(e.acc));
    end
  endtask

  task automatic release_out(input int u, input string name);
    out_ready[u] = 1'b1;
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk({name, " valid dropped"}, int'(out_valid[u]), 0);
    chk({name, " idle beat_cnt"}, get_bc(u), 0);
    chk({name, " idle in_ready"}, int'(in_ready[u]), 0);
  endtask

  task automatic check_reset(input int u, input string name);
    chk({name, " acc"}, get_acc(u), 0);
    chk({name, " out_valid"}, int'(out_valid[u]), 0);
    chk({name, " in_ready"}, int'(in_ready[u]), 0);
    chk({name, " ovf"}, int'(ovf[u]), 0);
    chk({name, " beat_cnt"}, get_bc(u), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    string nm;
    int    u;
    exp_t  e;

    vecs[0] = mk(0, 15, 225, 6, 100,   0, 0, 0, 0,  0, 346, 0);
    vecs[1] = mk(0, 15, 225, 6, 100,   1, 3, 0, 2,  5, 346, 0);
    vecs[2] = mk(1, 225, 225, 225, 225, 0, 0, 0, 0, 0, SAT ? 511 : 388, 1);
    vecs[3] = mk(0, 255, 255, 255, 255, 0, 2, 0, 1, 1, 1020, 0);
    vecs[4] = mk(1, 0, 0, 0, 0,        0, 0, 0, 0,  0, 0, 0);
    vecs[5] = mk(1, 200, 200, 100, 11, 0, 1, 0, 0,  0, 511, 0);
    vecs[6] = mk(1, 200, 200, 100, 12, 0, 0, 3, 0,  2, SAT ? 511 : 0, 1);

    prod[0] = '0;
    prod[1] = '0;
    repeat (2) @(negedge clk);
    check_reset(0, "reset u0");
    check_reset(1, "reset u1");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("vec%0d", i);
      u  = int'(vecs[i].u);
      pulse_start(u);
      e.acc = vecs[i].exp_acc;
      e.ovf = vecs[i].exp_ovf;
      sb_q.push_back(e);
      for (int b = 0; b < 4; b++) begin
        send(u, int'(vecs[i].beats[b]), int'(vecs[i].gaps[b]), nm);
        if (b < 3) chk($sformatf("%s beat_cnt after %0d", nm, b + 1), get_bc(u), b + 1);
        else       chk({nm, " valid one cycle after last beat"}, int'(out_valid[u]), 1);
      end
      wait_valid(u, nm);
      compare_head(u, int'(vecs[i].stall), nm);
      release_out(u, nm);
    end

    // Reset in the middle of a sum discards it; IN_READY stays low until START.
    pulse_start(0);
    send(0, 10, 0, "rst_mid");
    send(0, 20, 0, "rst_mid");
    chk("rst_mid beat_cnt", get_bc(0), 2);
    rst = 1'b1;
    #1;
    check_reset(0, "rst_mid async");
    @(negedge clk);
    rst = 1'b0;
    prod[0]     = 8'd50;
    in_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid in_ready before start", int'(in_ready[0]), 0);
      chk("rst_mid no partial output", int'(out_valid[0]), 0);
    end
    pulse_start(0);
    in_valid[0] = 1'b0;
    chk("rst_mid in_ready after start", int'(in_ready[0]), 1);
    chk("rst_mid beat_cnt after start", get_bc(0), 0);

    // Restart with a beat in the same cycle: that beat is beat 1 of the new sum.
    send(0, 10, 0, "restart");
    send(0, 20, 0, "restart");
    start[0]    = 1'b1;
    prod[0]     = 8'd1;
    in_valid[0] = 1'b1;
    e.acc = 16'd10;
    e.ovf = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    start[0]    = 1'b0;
    in_valid[0] = 1'b0;
    chk("restart beat_cnt", get_bc(0), 1);
    send(0, 2, 0, "restart");
    send(0, 3, 1, "restart");
    send(0, 4, 0, "restart");
    wait_valid(0, "restart");
    compare_head(0, 0, "restart");
    release_out(0, "restart");

    // Back-to-back sums: START alone in DONE is ignored, START with OUT_READY skips IDLE.
    pulse_start(0);
    e.acc = 16'd346;
    e.ovf = 1'b0;
    sb_q.push_back(e);
    send(0, 15, 0, "b2b first");
    send(0, 225, 0, "b2b first");
    send(0, 6, 0, "b2b first");
    send(0, 100, 0, "b2b first");
    wait_valid(0, "b2b first");
    pulse_start(0);
    chk("b2b lone start ignored valid", int'(out_valid[0]), 1);
    chk("b2b lone start ignored in_ready", int'(in_ready[0]), 0);
    compare_head(0, 0, "b2b first");
    start[0]     = 1'b1;
    out_ready[0] = 1'b1;
    e.acc = 16'd228;
    e.ovf = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    start[0]     = 1'b0;
    out_ready[0] = 1'b0;
    chk("b2b transfer valid dropped", int'(out_valid[0]), 0);
    chk("b2b straight to accum", int'(in_ready[0]), 1);
    chk("b2b cleared beat_cnt", get_bc(0), 0);
    send(0, 225, 0, "b2b second");
    send(0, 1, 0, "b2b second");
    send(0, 1, 0, "b2b second");
    send(0, 1, 0, "b2b second");
    wait_valid(0, "b2b second");
    compare_head(0, 0, "b2b second");
    release_out(0, "b2b second");

    chk("scoreboard drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
